// File: rtl/input_mems_db.sv
// Double-buffered X/W input memory: AXIS loader fills one X bank while the core reads the other.
// Reads return one cycle after the address; TREADY stalls a packet's first beat until its target bank(s) drain.
module input_mems_db #(
  parameter  int INW         = 10,
  parameter  int R           = 15,
  parameter  int C           = 13,
  parameter  int MAXK        = 7,
  parameter  int NRP         = 4,
  localparam int K_BITS      = $clog2(MAXK+1),
  localparam int X_ADDR_BITS = $clog2(R*C),
  localparam int W_ADDR_BITS = $clog2(MAXK*MAXK)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INW-1:0]                AXIS_TDATA,
  input  logic                          AXIS_TVALID,
  input  logic [K_BITS:0]               AXIS_TUSER,
  output logic                          AXIS_TREADY,
  output logic                          inputs_loaded,
  input  logic                          compute_finished,
  output logic [K_BITS-1:0]             K,
  output logic signed [INW-1:0]         B,
  input  logic [NRP*X_ADDR_BITS-1:0]    X_read_addr,
  output logic [NRP*INW-1:0]            X_data,
  input  logic [NRP*W_ADDR_BITS-1:0]    W_read_addr,
  output logic [NRP*INW-1:0]            W_data
);

  typedef enum logic [1:0] {L_IDLE, L_W, L_B, L_X} state_t;

  state_t                  r_state;
  logic [1:0]              r_full;
  logic                    r_fill_ptr;
  logic                    r_comp_ptr;
  logic [W_ADDR_BITS-1:0]  r_w_cnt;
  logic [X_ADDR_BITS-1:0]  r_x_cnt;
  logic [K_BITS-1:0]       r_k;
  logic signed [INW-1:0]   r_b;

  logic [INW-1:0] r_xmem [2][NRP][R*C];
  logic [INW-1:0] r_wmem [NRP][MAXK*MAXK];
  logic [INW-1:0] r_xdata [NRP];
  logic [INW-1:0] r_wdata [NRP];

  logic                    w_new_w;
  logic [K_BITS-1:0]       w_user_k;
  logic                    w_tready;
  logic                    w_acc;
  logic [2*K_BITS-1:0]     w_kk;
  logic                    w_w_last;
  logic                    w_x_last;
  logic                    w_w_we;
  logic [W_ADDR_BITS-1:0]  w_w_addr;
  logic                    w_x_we;
  logic [X_ADDR_BITS-1:0]  w_x_addr;

  assign w_new_w  = AXIS_TUSER[0];
  assign w_user_k = AXIS_TUSER[K_BITS:1];
  assign w_kk     = (2*K_BITS)'(r_k) * (2*K_BITS)'(r_k);
  assign w_w_last = (32'(r_w_cnt) + 32'd1) == 32'(w_kk);
  assign w_x_last = r_x_cnt == X_ADDR_BITS'(R*C-1);

  // A new_W packet must wait for both banks so K/B/W never change under an active compute.
  always_comb begin
    w_tready = 1'b0;
    if (!reset) begin
      if (r_state == L_IDLE)
        w_tready = w_new_w ? (r_full == 2'b00) : !r_full[r_fill_ptr];
      else
        w_tready = 1'b1;
    end
  end

  assign AXIS_TREADY   = w_tready;
  assign w_acc         = AXIS_TVALID && w_tready;
  assign inputs_loaded = r_full[r_comp_ptr];
  assign K             = r_k;
  assign B             = r_b;

  always_comb begin
    w_w_we   = 1'b0;
    w_w_addr = r_w_cnt;
    w_x_we   = 1'b0;
    w_x_addr = r_x_cnt;
    if (w_acc) begin
      case (r_state)
        L_IDLE: begin
          if (w_new_w) begin
            w_w_we   = (w_user_k != '0);
            w_w_addr = '0;
          end else begin
            w_x_we   = 1'b1;
            w_x_addr = '0;
          end
        end
        L_W:     w_w_we = 1'b1;
        L_X:     w_x_we = 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is never cleared; every write lands in all NRP copies.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRP; i++) begin
      if (w_w_we) r_wmem[i][w_w_addr] <= AXIS_TDATA;
      if (w_x_we) r_xmem[r_fill_ptr][i][w_x_addr] <= AXIS_TDATA;
      r_xdata[i] <= r_xmem[r_comp_ptr][i][X_read_addr[i*X_ADDR_BITS +: X_ADDR_BITS]];
      r_wdata[i] <= r_wmem[i][W_read_addr[i*W_ADDR_BITS +: W_ADDR_BITS]];
    end
  end

  for (genvar g = 0; g < NRP; g++) begin : g_rd
    assign X_data[g*INW +: INW] = r_xdata[g];
    assign W_data[g*INW +: INW] = r_wdata[g];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= L_IDLE;
      r_full     <= 2'b00;
      r_fill_ptr <= 1'b0;
      r_comp_ptr <= 1'b0;
      r_w_cnt    <= '0;
      r_x_cnt    <= '0;
      r_k        <= '0;
      r_b        <= '0;
    end else begin
      // Release and load completion never hit the same bank: a bank being filled is empty.
      if (compute_finished && r_full[r_comp_ptr]) begin
        r_full[r_comp_ptr] <= 1'b0;
        r_comp_ptr         <= ~r_comp_ptr;
      end
      if (w_acc) begin
        case (r_state)
          L_IDLE: begin
            if (w_new_w) begin
              r_k <= w_user_k;
              if (w_user_k >= K_BITS'(2)) begin
                r_w_cnt <= W_ADDR_BITS'(1);
                r_state <= L_W;
              end else begin
                r_state <= L_B;
              end
            end else begin
              r_x_cnt <= X_ADDR_BITS'(1);
              r_state <= L_X;
            end
          end
          L_W: begin
            r_w_cnt <= r_w_cnt + W_ADDR_BITS'(1);
            if (w_w_last) r_state <= L_B;
          end
          L_B: begin
            r_b     <= AXIS_TDATA;
            r_x_cnt <= '0;
            r_state <= L_X;
          end
          L_X: begin
            r_x_cnt <= r_x_cnt + X_ADDR_BITS'(1);
            if (w_x_last) begin
              r_full[r_fill_ptr] <= 1'b1;
              r_fill_ptr         <= ~r_fill_ptr;
              r_x_cnt            <= '0;
              r_state            <= L_IDLE;
            end
          end
          default: r_state <= L_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_mems_db.sv
// Randomized bench for input_mems_db: packet driver + bank-level reference model, read scoreboard.
module tb_input_mems_db;
  localparam int INW    = 10;
  localparam int R      = 15;
  localparam int C      = 13;
  localparam int MAXK   = 7;
  localparam int NRP    = 4;
  localparam int K_BITS = $clog2(MAXK+1);
  localparam int XB     = $clog2(R*C);
  localparam int WB     = $clog2(MAXK*MAXK);
  localparam int RC     = R*C;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [INW-1:0]       tdata;
  logic                 tvalid;
  logic [K_BITS:0]      tuser;
  logic                 tready;
  logic                 inputs_loaded;
  logic                 compute_finished;
  logic [K_BITS-1:0]    k_out;
  logic [INW-1:0]       b_out;
  logic [NRP*XB-1:0]    x_rd;
  logic [NRP*INW-1:0]   x_data;
  logic [NRP*WB-1:0]    w_rd;
  logic [NRP*INW-1:0]   w_data;

  always #5 clk = ~clk;

  input_mems_db #(.INW(INW), .R(R), .C(C), .MAXK(MAXK), .NRP(NRP)) dut (
    .clk(clk), .reset(reset),
    .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TUSER(tuser), .AXIS_TREADY(tready),
    .inputs_loaded(inputs_loaded), .compute_finished(compute_finished),
    .K(k_out), .B(b_out),
    .X_read_addr(x_rd), .X_data(x_data),
    .W_read_addr(w_rd), .W_data(w_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: image contents per bank, bank occupancy, and the shared K/B/W set.
  logic [INW-1:0] m_bank [2][RC];
  logic [INW-1:0] m_w [MAXK*MAXK];
  logic [INW-1:0] m_b;
  int             m_k;
  bit             m_full [2];
  int             m_fill;
  int             m_comp;

  logic [INW-1:0] pw [MAXK*MAXK];
  logic [INW-1:0] px [RC];

  typedef struct packed {
    logic [NRP*INW-1:0] x;
    logic [NRP*INW-1:0] w;
    logic [NRP-1:0]     wchk;
    logic [K_BITS-1:0]  k;
    logic [INW-1:0]     b;
    logic               ld;
  } exp_t;

  exp_t sb[$];
  logic rd_req = 1'b0;

  always @(posedge clk) begin : monitor
    exp_t e;
    if (rd_req) begin
      #1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        for (int p = 0; p < NRP; p++) begin
          chk("x_data", 32'(x_data[p*INW +: INW]), 32'(e.x[p*INW +: INW]));
          if (e.wchk[p]) chk("w_data", 32'(w_data[p*INW +: INW]), 32'(e.w[p*INW +: INW]));
        end
        chk("k_out", 32'(k_out), 32'(e.k));
        chk("b_out", 32'(b_out), 32'(e.b));
        chk("inputs_loaded_rd", 32'(inputs_loaded), 32'(e.ld));
      end
    end
  end

  function automatic void apply_beat(input bit nw, input int k, input int nwb, input int j,
                                     input logic [INW-1:0] d);
    int xi;
    if (nw && j == 0) m_k = k;
    if (nw && j < nwb) begin
      if (k > 0) m_w[j] = d;
    end else if (nw && j == nwb) begin
      m_b = d;
    end else begin
      xi = nw ? j - nwb - 1 : j;
      m_bank[m_fill][xi] = d;
      if (xi == RC-1) begin
        m_full[m_fill] = 1'b1;
        m_fill = 1 - m_fill;
      end
    end
  endfunction

  task automatic send_packet(input bit nw, input int k, input logic [INW-1:0] b, input int stop_after);
    int nwb, nb, waitc;
    logic [INW-1:0] d;
    bit rdy, exp_rdy;
    nwb = nw ? ((k == 0) ? 1 : k*k) : 0;
    nb  = nw ? nwb + 1 + RC : RC;
    if (stop_after >= 0 && stop_after < nb) nb = stop_after;
    for (int j = 0; j < nb; j++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        tvalid = 1'b0;
        @(negedge clk);
      end
      if (!nw || j > nwb) d = px[j - (nw ? nwb + 1 : 0)];
      else if (j == nwb)  d = b;
      else                d = pw[j];
      tdata  = d;
      tuser  = {K_BITS'(k), nw};
      tvalid = 1'b1;
      waitc  = 0;
      forever begin
        #2;
        exp_rdy = (j == 0) ? (nw ? (!m_full[0] && !m_full[1]) : !m_full[m_fill]) : 1'b1;
        rdy = tready;
        chk("tready", 32'(rdy), 32'(exp_rdy));
        @(posedge clk);
        if (rdy) break;
        waitc++;
        if (waitc > 200) begin
          chk("stall_timeout", 32'd0, 32'd1);
          tvalid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      apply_beat(nw, k, nwb, j, d);
      #1 chk("inputs_loaded", 32'(inputs_loaded), 32'(m_full[m_comp]));
    end
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic finish_pulse();
    @(negedge clk);
    compute_finished = 1'b1;
    @(posedge clk);
    if (m_full[m_comp]) begin
      m_full[m_comp] = 1'b0;
      m_comp = 1 - m_comp;
    end
    @(negedge clk);
    compute_finished = 1'b0;
  endtask

  task automatic drain();
    repeat (2) if (m_full[0] || m_full[1]) finish_pulse();
  endtask

  // fx / fw >= 0 force the first read's X / W address on every port.
  task automatic do_reads(input int n, input int fx, input int fw);
    exp_t e;
    int xa, wa;
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      e = '0;
      for (int p = 0; p < NRP; p++) begin
        xa = $urandom_range(0, RC-1);
        if (r == 0 && fx >= 0) xa = fx;
        x_rd[p*XB +: XB]     = XB'(xa);
        e.x[p*INW +: INW]    = m_bank[m_comp][xa];
        if (m_k > 0) begin
          wa = $urandom_range(0, m_k*m_k - 1);
          if (r == 0 && fw >= 0) wa = fw;
          w_rd[p*WB +: WB]   = WB'(wa);
          e.w[p*INW +: INW]  = m_w[wa];
          e.wchk[p]          = 1'b1;
        end
      end
      e.k  = K_BITS'(m_k);
      e.b  = m_b;
      e.ld = m_full[m_comp];
      sb.push_back(e);
      rd_req = 1'b1;
    end
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    tvalid = 1'b0;
    tuser  = {K_BITS'(0), 1'b0};
    #2 chk("tready_in_reset", 32'(tready), 32'd0);
    @(posedge clk);
    #1;
    chk("loaded_after_reset", 32'(inputs_loaded), 32'd0);
    chk("k_after_reset", 32'(k_out), 32'd0);
    chk("b_after_reset", 32'(b_out), 32'd0);
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    m_fill = 0;
    m_comp = 0;
    m_k = 0;
    m_b = '0;
    @(negedge clk);
    reset = 1'b0;
    tuser = {K_BITS'(0), 1'b1};
    #2 chk("tready_after_reset", 32'(tready), 32'd1);
  endtask

  task automatic rand_px();
    for (int i = 0; i < RC; i++) px[i] = INW'($urandom_range(0, (1 << INW) - 1));
  endtask

  task automatic rand_pw();
    for (int i = 0; i < MAXK*MAXK; i++) pw[i] = INW'($urandom_range(0, (1 << INW) - 1));
  endtask

  initial begin
    int k;
    logic [INW-1:0] b;
    bit nw;
    reset = 1'b1;
    tvalid = 1'b0;
    tdata = '0;
    tuser = '0;
    compute_finished = 1'b0;
    x_rd = '0;
    w_rd = '0;
    m_k = 0;
    m_b = '0;
    m_fill = 0;
    m_comp = 0;
    m_full[0] = 1'b0;
    m_full[1] = 1'b0;
    do_reset();

    // Directed full load: K=3, W=1..9, B=-5, X[i]=i
    for (int i = 0; i < 9; i++) pw[i] = INW'(i + 1);
    for (int i = 0; i < RC; i++) px[i] = INW'(i);
    send_packet(1'b1, 3, INW'(-5), -1);
    do_reads(1, 100, 8);
    do_reads(12, -1, -1);

    // X-only packet loads into the second bank while the first is in use
    for (int i = 0; i < RC; i++) px[i] = INW'(i + 200);
    send_packet(1'b0, 0, '0, -1);
    do_reads(4, -1, -1);
    finish_pulse();
    chk("loaded_after_finish", 32'(inputs_loaded), 32'(m_full[m_comp]));
    do_reads(1, 0, -1);
    do_reads(8, -1, -1);

    // Fill both banks, then a third X-only packet stalls until a release
    rand_px();
    send_packet(1'b0, 0, '0, -1);
    rand_px();
    fork
      send_packet(1'b0, 0, '0, -1);
      begin repeat (6) @(negedge clk); finish_pulse(); end
    join
    do_reads(8, -1, -1);

    // new_W packet stalls until both banks drain
    rand_pw();
    rand_px();
    k = $urandom_range(2, MAXK);
    b = INW'($urandom_range(0, (1 << INW) - 1));
    fork
      send_packet(1'b1, k, b, -1);
      begin
        repeat (4) @(negedge clk);
        finish_pulse();
        repeat (5) @(negedge clk);
        finish_pulse();
      end
    join
    do_reads(10, -1, -1);

    // K=1 packet
    drain();
    rand_px();
    pw[0] = INW'($urandom_range(0, (1 << INW) - 1));
    send_packet(1'b1, 1, INW'(7), -1);
    do_reads(1, -1, 0);
    do_reads(6, -1, -1);

    // Random mix, including K=0
    for (int it = 0; it < 5; it++) begin
      nw = 1'($urandom_range(0, 1));
      if (nw) drain();
      else if (m_full[0] && m_full[1]) finish_pulse();
      rand_pw();
      rand_px();
      k = $urandom_range(0, MAXK);
      b = INW'($urandom_range(0, (1 << INW) - 1));
      send_packet(nw, k, b, -1);
      if (m_full[m_comp]) do_reads(5, -1, -1);
    end

    // Reset part-way through the X phase, then a fresh packet into bank 0
    drain();
    rand_pw();
    rand_px();
    k = $urandom_range(1, MAXK);
    b = INW'($urandom_range(0, (1 << INW) - 1));
    send_packet(1'b1, k, b, k*k + 1 + 50);
    do_reset();
    rand_pw();
    rand_px();
    k = $urandom_range(1, MAXK);
    b = INW'($urandom_range(0, (1 << INW) - 1));
    send_packet(1'b1, k, b, -1);
    do_reads(1, 0, 0);
    do_reads(8, -1, -1);

    // X-only packet straight after reset uses K=0, B=0
    do_reset();
    rand_px();
    send_packet(1'b0, 0, '0, -1);
    do_reads(6, -1, -1);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/input_mems_db.md
# input_mems_db

Double-buffered, N-read-port successor to the convolution accelerator's input memory. It accepts W, B and X over an AXI-Stream slave and stores X in two banks, so the next X image loads while the compute core reads the current one. The core sees a variable number of read ports for X and W, with one-cycle synchronous read latency. The block sits between the AXIS input and the MAC/convolution core.

## Interface
- INW, 10: data width of W, B and X (signed).
- R, 15: X rows.
- C, 13: X columns.
- MAXK, 7: maximum kernel size.
- NRP, 4: number of read ports; each port has one X and one W read port.
- Derived (localparam) K_BITS = $clog2(MAXK+1).
- Derived (localparam) X_ADDR_BITS = $clog2(R*C).
- Derived (localparam) W_ADDR_BITS = $clog2(MAXK*MAXK).

Ports:
- clk, in, 1: single clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high.
- AXIS_TDATA, in, INW: stream data.
- AXIS_TVALID, in, 1: stream valid.
- AXIS_TUSER, in, K_BITS+1: bit 0 is new_W; bits [K_BITS:1] are K. Sampled on the first beat of a packet only.
- AXIS_TREADY, out, 1: stream ready.
- inputs_loaded, out, 1: the compute bank holds a complete X image.
- compute_finished, in, 1: one-cycle pulse from the core; releases the compute bank.
- K, out, K_BITS: current kernel size.
- B, out, INW signed: current bias.
- X_read_addr, in, NRP*X_ADDR_BITS: port i uses [i*X_ADDR_BITS +: X_ADDR_BITS].
- X_data, out, NRP*INW: X read data from the compute bank; port i uses [i*INW +: INW].
- W_read_addr, in, NRP*W_ADDR_BITS: W read addresses, same slicing as X_read_addr.
- W_data, out, NRP*INW: W read data, same slicing as X_data.

## Operation
- Storage:
  - 2 banks × NRP copies of an R*C X memory.
  - NRP copies of a MAXK*MAXK W memory.
  - One K register and one B register, shared by both banks.
  - Every write goes to all NRP copies of the target memory.
- State:
  - full[1:0]: per-bank full flags.
  - fill_ptr: bank being loaded.
  - comp_ptr: bank being read.
  - w_cnt: W write counter.
  - x_cnt: X write counter.
- Packet formats:
  - new_W=1: K*K W beats, then 1 B beat, then R*C X beats.
  - new_W=0: R*C X beats only; K, B and W are reused.
- Load FSM, states L_IDLE, L_W, L_B, L_X:
  - L_IDLE, new_W=1: AXIS_TREADY = (full==2'b00).
  - L_IDLE, new_W=0: AXIS_TREADY = !full[fill_ptr].
  - L_IDLE, accepted beat with new_W=1: latch K from TUSER.
    - K≥2: write W[0], set w_cnt=1, go to L_W.
    - K=1: write W[0], go to L_B.
    - K=0: discard the beat, go to L_B.
  - L_IDLE, accepted beat with new_W=0: write X[0] into fill_ptr, set x_cnt=1, go to L_X.
  - L_W: AXIS_TREADY=1. Each accepted beat writes W[w_cnt] and increments w_cnt. The beat at w_cnt == K*K-1 (2*K_BITS-wide product) moves to L_B.
  - L_B: AXIS_TREADY=1. The accepted beat latches B, sets x_cnt=0, and moves to L_X.
  - L_X: AXIS_TREADY=1. Each accepted beat writes X[x_cnt] into bank fill_ptr. The beat at x_cnt == R*C-1 sets full[fill_ptr], toggles fill_ptr, and moves to L_IDLE.
- Compute side:
  - inputs_loaded = full[comp_ptr].
  - compute_finished while inputs_loaded clears full[comp_ptr] and toggles comp_ptr.
  - compute_finished while !inputs_loaded is ignored.
- Read path: X memories of bank comp_ptr drive X_data. W memories drive W_data. Reads are valid only while inputs_loaded.
- Arithmetic: addresses and counters are unsigned. B is stored bit-exact as signed INW. There is no saturation.

## Timing
- Reset values: AXIS_TREADY=0 in the reset cycle, 1 in the first cycle after reset (L_IDLE, banks empty). All other values after reset:
  - inputs_loaded=0, K=0, B=0.
  - full=0, fill_ptr=0, comp_ptr=0.
  - counters 0, state L_IDLE.
  - Memory contents are not cleared.
- Reset mid-packet aborts the packet. The next packet starts writing at address 0 of bank 0.
- inputs_loaded rises in the cycle after the last X beat is accepted.
- If both banks are full, inputs_loaded stays 1 through compute_finished. From the next cycle it reflects the other bank.
- Read latency: X_data and W_data are valid 1 cycle after the address is presented.
- Simultaneous load completion on fill_ptr and compute_finished on comp_ptr:
  - Both take effect in the same cycle.
  - They target different banks.
  - When fill_ptr==comp_ptr, that bank is empty, so compute_finished is ignored.
- A new_W=1 packet stalls on its first beat until both banks drain. This guarantees K, B and W never change under an active compute.
- A new_W=0 packet after reset with no prior W is accepted. It uses K=0, B=0.

## Test plan
- Full load with K=3, W=1..9, B=-5, X[i]=i:
  - inputs_loaded=1 one cycle after beat 9+1+195.
  - K=3, B=-5.
  - X_read_addr port 2 = 100 gives X_data port 2 = 100 one cycle later.
  - W_read_addr port 0 = 8 gives W_data port 0 = 9.
- X-only packet X[i]=i+200 during compute:
  - All 195 beats are accepted with TREADY=1.
  - After compute_finished, inputs_loaded stays 1 and address 0 reads 200.
  - W, K and B are unchanged.
- Third X-only packet while both banks are full: TREADY=0 until compute_finished, then 1 in the next cycle.
- new_W=1 first beat while one bank is full: TREADY=0 until the final compute_finished, then the packet loads normally.
- K=1 packet: 1 W beat, then B=7, then X. K=1, B=7, W[0] is correct.
- Reset asserted mid-way through L_X, at beat 50:
  - Next cycle: inputs_loaded=0, K=0, B=0.
  - TREADY=1 from the first cycle after reset.
  - A fresh full packet loads into bank 0 from address 0.
